// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_pkg
// Description : Shared state encoding, sequencing constants and helpers for
//               the March-style memory BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bist_pkg;

    // Controller states: one write sweep, three read/compare sweeps.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_R0W1 = 3'd2,
        ST_R1W0 = 3'd3,
        ST_RFIN = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Address sweep direction.
    localparam logic c_dir_up = 1'b1;
    localparam logic c_dir_dn = 1'b0;

    // Sub-cycle within a read/compare address slot.
    localparam logic c_sub_a = 1'b0;   // address presented, no write
    localparam logic c_sub_b = 1'b1;   // data compared, optional write

    // Only the R1W0 sweep walks the address space downward.
    function automatic logic phase_dir(input state_t s);
        return (s == ST_R1W0) ? c_dir_dn : c_dir_up;
    endfunction

    // True for the sweeps that read and compare memory contents.
    function automatic logic is_read_phase(input state_t s);
        return (s == ST_R0W1) || (s == ST_R1W0) || (s == ST_RFIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bist_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_addr_cnt
// Description : Up/down address sequencer with load-to-0 / load-to-top and a
//               direction-aware terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_addr_cnt
    import mem_bist_pkg::*;
#(
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_load_top,
    input  logic            i_step,
    input  logic            i_dir,
    output logic [ADDR-1:0] o_count,
    output logic            o_tc
);

    localparam logic [ADDR-1:0] c_one = ADDR'(1);
    localparam logic [ADDR-1:0] c_top = '1;

    logic [ADDR-1:0] r_count;

    // Load takes priority over stepping so a phase change never skips an address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_top ? c_top : '0;
        end else if (i_step) begin
            r_count <= (i_dir == c_dir_up) ? (r_count + c_one) : (r_count - c_one);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (i_dir == c_dir_up) ? (r_count == c_top) : (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_bist.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist
// Description : Memory BIST controller running W0 / R0W1 / R1W0(down) / RFIN
//               sweeps against a background word; reports the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int              ADDR    = 4,
    parameter int              WORD    = 4,
    parameter logic [WORD-1:0] PATTERN = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_data_in,
    output logic            mem_wr,
    input  logic [WORD-1:0] mem_data_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ADDR-1:0] fail_addr,
    output logic [WORD-1:0] fail_data
);

    state_t          r_state;
    logic            r_sub;
    logic            r_wr;
    logic [WORD-1:0] r_data_in;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [ADDR-1:0] r_fail_addr;
    logic [WORD-1:0] r_fail_data;

    logic [ADDR-1:0] w_cnt;
    logic            w_tc;
    logic            w_dir;
    logic            w_load;
    logic            w_load_top;
    logic            w_step;
    logic            w_cmp;
    logic [WORD-1:0] w_expect;
    logic            w_mismatch;

    mem_bist_addr_cnt #(
        .ADDR (ADDR)
    ) u_addr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_top (w_load_top),
        .i_step     (w_step),
        .i_dir      (w_dir),
        .o_count    (w_cnt),
        .o_tc       (w_tc)
    );

    assign w_dir      = phase_dir(r_state);
    assign w_cmp      = is_read_phase(r_state) && (r_sub == c_sub_b);
    assign w_expect   = (r_state == ST_R1W0) ? ~PATTERN : PATTERN;
    assign w_mismatch = w_cmp && (mem_data_out != w_expect);

    // The compare-cycle write is suppressed in the very cycle a mismatch is seen.
    assign mem_wr      = r_wr && !w_mismatch;
    assign mem_addr    = w_cnt;
    assign mem_data_in = r_data_in;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;

    // Address sequencer control: advance after each write (W0) or compare slot.
    always_comb begin
        w_load     = 1'b0;
        w_load_top = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            ST_IDLE: w_load = start;
            ST_W0: begin
                if (w_tc) w_load = 1'b1;
                else      w_step = 1'b1;
            end
            ST_R0W1, ST_R1W0, ST_RFIN: begin
                if (r_sub == c_sub_b && !w_mismatch) begin
                    if (w_tc) begin
                        w_load     = 1'b1;
                        w_load_top = (r_state == ST_R0W1);
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Main sequencer: state, registered write strobe/data, status and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sub       <= c_sub_a;
            r_wr        <= 1'b0;
            r_data_in   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_W0;
                        r_sub       <= c_sub_a;
                        r_wr        <= 1'b1;
                        r_data_in   <= PATTERN;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                    end
                end
                ST_W0: begin
                    if (w_tc) begin
                        r_state <= ST_R0W1;
                        r_sub   <= c_sub_a;
                        r_wr    <= 1'b0;
                    end
                end
                ST_R0W1, ST_R1W0, ST_RFIN: begin
                    if (r_sub == c_sub_a) begin
                        r_sub     <= c_sub_b;
                        r_wr      <= (r_state != ST_RFIN);
                        r_data_in <= (r_state == ST_R0W1) ? ~PATTERN : PATTERN;
                    end else if (w_mismatch) begin
                        r_state     <= ST_DONE;
                        r_sub       <= c_sub_a;
                        r_wr        <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail_addr <= w_cnt;
                        r_fail_data <= mem_data_out;
                    end else begin
                        r_sub <= c_sub_a;
                        r_wr  <= 1'b0;
                        if (w_tc) begin
                            case (r_state)
                                ST_R0W1: r_state <= ST_R1W0;
                                ST_R1W0: r_state <= ST_RFIN;
                                default: begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_pass  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_done    <= 1'b0;
                    r_data_in <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wr    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
